// File: rtl/stim_multi_config_controller.sv
// Multi-channel stim configuration controller: divides DATACLK_HZ by the request frequency,
// validates timing, then programs each masked channel's sequencer registers. Optional macro: STIM_CFG_AMP_SETTLE_EN.
module stim_multi_config_controller #(
  parameter logic [31:0] DATACLK_HZ = 32'd30000,
  parameter int          NUM_CH     = 16,
  parameter int          START_DLY  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_module,
  input  logic [NUM_CH-1:0] req_ch_mask,
  input  logic [15:0]       req_freq_hz,
  input  logic [15:0]       req_phase_len,
  input  logic [15:0]       req_interphase,
  input  logic [7:0]        req_num_pulses,
  input  logic [4:0]        req_trig_src,
  output logic [4:0]        prog_module,
  output logic [3:0]        prog_channel,
  output logic [3:0]        prog_address,
  output logic [15:0]       prog_word,
  output logic              prog_trig,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       cur_period
);

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_CHECK, S_SCAN, S_SET, S_TRIG, S_DONE, S_ERR
  } state_t;

`ifdef STIM_CFG_AMP_SETTLE_EN
  localparam logic [2:0] LAST_WR = 3'd6;
`else
  localparam logic [2:0] LAST_WR = 3'd5;
`endif
  localparam logic [4:0] CH_END = 5'(NUM_CH);

  function automatic logic [3:0] wr_addr(input logic [2:0] k);
`ifdef STIM_CFG_AMP_SETTLE_EN
    case (k)
      3'd0:    wr_addr = 4'd0;
      3'd1:    wr_addr = 4'd1;
      3'd2:    wr_addr = 4'd2;
      3'd3:    wr_addr = 4'd4;
      3'd4:    wr_addr = 4'd5;
      3'd5:    wr_addr = 4'd7;
      default: wr_addr = 4'd13;
    endcase
`else
    case (k)
      3'd0:    wr_addr = 4'd0;
      3'd1:    wr_addr = 4'd1;
      3'd2:    wr_addr = 4'd4;
      3'd3:    wr_addr = 4'd5;
      3'd4:    wr_addr = 4'd7;
      default: wr_addr = 4'd13;
    endcase
`endif
  endfunction

  state_t            r_state;
  logic [4:0]        r_module;
  logic [NUM_CH-1:0] r_mask;
  logic [15:0]       r_freq;
  logic [15:0]       r_phase_len;
  logic [15:0]       r_interphase;
  logic [7:0]        r_num_pulses;
  logic [4:0]        r_trig_src;
  logic [31:0]       r_num;
  logic [15:0]       r_rem;
  logic [4:0]        r_div_cnt;
  logic [15:0]       r_phase2;
  logic [15:0]       r_end_stim;
  logic [15:0]       r_event_end;
  logic [4:0]        r_ch_idx;
  logic [2:0]        r_wr_idx;

  logic        r_req_ready, r_busy, r_done, r_err, r_prog_trig;
  logic [4:0]  r_prog_module;
  logic [3:0]  r_prog_channel, r_prog_address;
  logic [15:0] r_prog_word, r_cur_period;

  state_t      w_state_next;
  logic [4:0]  w_ch_next;
  logic [2:0]  w_wr_next;
  logic        w_wr_active;
  logic [3:0]  w_addr_next;
  logic [15:0] w_word_next;
  logic [15:0] w_mask16;

  // Restoring divider step: r_num holds the dividend shifting out and quotient bits shifting in.
  logic [16:0] w_rem_shift;
  logic        w_ge;
  logic [15:0] w_rem_sub;
  assign w_rem_shift = {r_rem, r_num[31]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_freq});
  assign w_rem_sub   = w_rem_shift[15:0] - r_freq;

  logic [31:0] w_qm1;
  logic [15:0] w_event_end;
  logic [17:0] w_phase2, w_end_stim;
  logic        w_reject;
  assign w_qm1       = r_num - 32'd1;
  assign w_event_end = (|w_qm1[31:16]) ? 16'hFFFF : w_qm1[15:0];
  assign w_phase2    = 18'(START_DLY) + {2'b00, r_phase_len} + {2'b00, r_interphase};
  assign w_end_stim  = w_phase2 + {2'b00, r_phase_len};
  assign w_reject    = (r_freq == 16'd0) || (r_num == 32'd0) ||
                       (w_phase2 > 18'd65535) || (w_end_stim > 18'd65535) ||
                       ({2'b00, w_event_end} <= w_end_stim);
  assign w_mask16    = 16'(r_mask);

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch_idx;
    w_wr_next    = r_wr_idx;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = (req_freq_hz == 16'd0) ? S_CHECK : S_DIV;
      S_DIV:   if (r_div_cnt == 5'd31) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_reject) begin
          w_state_next = S_ERR;
        end else begin
          w_state_next = S_SCAN;
          w_ch_next    = 5'd0;
        end
      end
      S_SCAN: begin
        if (r_ch_idx >= CH_END) begin
          w_state_next = S_DONE;
        end else if (w_mask16[r_ch_idx[3:0]]) begin
          w_state_next = S_SET;
          w_wr_next    = 3'd0;
        end else begin
          w_ch_next = r_ch_idx + 5'd1;
        end
      end
      S_SET:   w_state_next = S_TRIG;
      S_TRIG: begin
        if (r_wr_idx == LAST_WR) begin
          w_state_next = S_SCAN;
          w_ch_next    = r_ch_idx + 5'd1;
        end else begin
          w_state_next = S_SET;
          w_wr_next    = r_wr_idx + 3'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so every port comes straight from a flop.
    w_wr_active = (w_state_next == S_SET) || (w_state_next == S_TRIG);
    w_addr_next = w_wr_active ? wr_addr(w_wr_next) : 4'd0;
    w_word_next = 16'd0;
    if (w_wr_active) begin
      case (w_addr_next)
        4'd0:    w_word_next = {8'h00, 3'b110, r_trig_src};
        4'd1:    w_word_next = {8'h00, r_num_pulses};
        4'd4:    w_word_next = 16'(START_DLY);
        4'd5:    w_word_next = r_phase2;
        4'd7:    w_word_next = r_end_stim;
        4'd13:   w_word_next = r_event_end;
        default: w_word_next = 16'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_module       <= '0;
      r_mask         <= '0;
      r_freq         <= '0;
      r_phase_len    <= '0;
      r_interphase   <= '0;
      r_num_pulses   <= '0;
      r_trig_src     <= '0;
      r_num          <= '0;
      r_rem          <= '0;
      r_div_cnt      <= '0;
      r_phase2       <= '0;
      r_end_stim     <= '0;
      r_event_end    <= '0;
      r_ch_idx       <= '0;
      r_wr_idx       <= '0;
      r_req_ready    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_prog_trig    <= 1'b0;
      r_prog_module  <= '0;
      r_prog_channel <= '0;
      r_prog_address <= '0;
      r_prog_word    <= '0;
      r_cur_period   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_ch_idx       <= w_ch_next;
      r_wr_idx       <= w_wr_next;
      r_req_ready    <= (w_state_next == S_IDLE);
      r_busy         <= (w_state_next != S_IDLE);
      r_done         <= (w_state_next == S_DONE);
      r_err          <= (w_state_next == S_ERR);
      r_prog_trig    <= (w_state_next == S_TRIG);
      r_prog_module  <= w_wr_active ? r_module : 5'd0;
      r_prog_channel <= w_wr_active ? w_ch_next[3:0] : 4'd0;
      r_prog_address <= w_addr_next;
      r_prog_word    <= w_word_next;
      if (r_state == S_IDLE && req_valid) begin
        r_module     <= req_module;
        r_mask       <= req_ch_mask;
        r_freq       <= req_freq_hz;
        r_phase_len  <= req_phase_len;
        r_interphase <= req_interphase;
        r_num_pulses <= req_num_pulses;
        r_trig_src   <= req_trig_src;
        r_num        <= DATACLK_HZ;
        r_rem        <= '0;
        r_div_cnt    <= '0;
      end
      if (r_state == S_DIV) begin
        r_rem     <= w_ge ? w_rem_sub : w_rem_shift[15:0];
        r_num     <= {r_num[30:0], w_ge};
        r_div_cnt <= r_div_cnt + 5'd1;
      end
      if (r_state == S_CHECK) begin
        r_phase2    <= w_phase2[15:0];
        r_end_stim  <= w_end_stim[15:0];
        r_event_end <= w_event_end;
      end
      if (w_state_next == S_DONE) r_cur_period <= r_event_end;
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign prog_trig    = r_prog_trig;
  assign prog_module  = r_prog_module;
  assign prog_channel = r_prog_channel;
  assign prog_address = r_prog_address;
  assign prog_word    = r_prog_word;
  assign cur_period   = r_cur_period;

endmodule
